// File: rtl/spi_master_link.sv
// Byte-oriented SPI master (mode 0, MSB first) with valid/ready byte input.
// A burst is framed by CS and ends after the byte flagged tx_last.
module spi_master_link #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, NEXT, HOLD, GAP} state_e;

  localparam logic [7:0] DIV_TC   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_TC = 8'(CS_SETUP);
  localparam logic [7:0] HOLD_TC  = 8'(CS_HOLD - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       last_q, last_d;
  logic       sclk_q, sclk_d;
  logic       cs_n_q, cs_n_d;
  logic       mosi_q, mosi_d;
  logic       tx_ready_q, tx_ready_d;
  logic       rx_valid_q, rx_valid_d;
  logic       accept, tick, last_fall;

  assign accept    = tx_valid & tx_ready_q;
  assign tick      = (cnt_q == DIV_TC);
  assign last_fall = tick & sclk_q & (bit_cnt_q == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (cnt_q == SETUP_TC) state_d = XFER;
      XFER:    if (last_fall) state_d = last_q ? HOLD : NEXT;
      NEXT:    if (accept) state_d = XFER;
      HOLD:    if (cnt_q == HOLD_TC) state_d = GAP;
      GAP:     if (cnt_q == HOLD_TC) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The shared counter times SETUP/HOLD/GAP and doubles as the SCLK divider in XFER.
  always_comb begin
    cnt_d      = cnt_q + 8'd1;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    last_d     = last_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    tx_ready_d = (state_d == IDLE) || (state_d == NEXT);
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE, NEXT: begin
        cnt_d  = 8'd0;
        sclk_d = 1'b0;
        if (state_q == IDLE) cs_n_d = 1'b1;
        if (accept) begin
          tx_shift_d = tx_data;
          last_d     = tx_last;
          mosi_d     = tx_data[7];
          bit_cnt_d  = 3'd0;
          cs_n_d     = 1'b0;
        end
      end
      SETUP: if (state_d != SETUP) cnt_d = 8'd0;
      XFER: begin
        if (tick) begin
          cnt_d  = 8'd0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_shift_d = {rx_shift_q[6:0], spi_miso};
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = rx_shift_q;
              rx_valid_d = 1'b1;
            end else begin
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
              mosi_d     = tx_shift_q[6];
            end
          end
        end
      end
      HOLD: begin
        if (state_d == GAP) begin
          cnt_d  = 8'd0;
          cs_n_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= 8'd0;
      bit_cnt_q  <= 3'd0;
      tx_shift_q <= 8'd0;
      rx_shift_q <= 8'd0;
      rx_data_q  <= 8'd0;
      last_q     <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      last_q     <= last_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign spi_sclk = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_link.sv
// Directed bench for spi_master_link: one instance at default timing with a
// loopback/responder slave, a second at the fastest legal timing in loopback.
module tb_spi_master_link;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       tx_valid, tx_last, tx_ready, rx_valid, busy;
  logic [7:0] tx_data, rx_data;
  logic       spi_sclk, spi_cs_n, spi_mosi, spi_miso;
  logic       tx_valid_2, tx_last_2, tx_ready_2, rx_valid_2, busy_2;
  logic [7:0] tx_data_2, rx_data_2;
  logic       spi_sclk_2, spi_cs_n_2, spi_mosi_2, spi_miso_2;
  logic       loopback = 1'b1;

  int check_count = 0;
  int error_count = 0;

  spi_master_link #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_last(tx_last), .tx_ready(tx_ready), .rx_valid(rx_valid),
    .rx_data(rx_data), .busy(busy), .spi_sclk(spi_sclk),
    .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_master_link #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)) dut_2 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_2), .tx_data(tx_data_2),
    .tx_last(tx_last_2), .tx_ready(tx_ready_2), .rx_valid(rx_valid_2),
    .rx_data(rx_data_2), .busy(busy_2), .spi_sclk(spi_sclk_2),
    .spi_cs_n(spi_cs_n_2), .spi_mosi(spi_mosi_2), .spi_miso(spi_miso_2)
  );

  // Mode-0 responder slave: drives MISO from a fixed response list, captures MOSI.
  localparam logic [7:0] RESP [5] = '{8'h3C, 8'hC3, 8'h00, 8'h00, 8'hA7};
  int         resp_idx = 0;
  int         slave_bits = 0;
  logic [7:0] slave_tx = 8'h00;
  logic [7:0] slave_shift = 8'h00;
  logic       slave_prev_sclk = 1'b0;
  logic       slave_prev_cs = 1'b1;
  logic [7:0] slave_rx_q[$];

  always @(spi_sclk or spi_cs_n) begin
    if (spi_cs_n === 1'b1) begin
      slave_bits = 0;
    end else if (slave_prev_cs === 1'b1) begin
      if (!loopback) begin
        slave_tx = (resp_idx < 5) ? RESP[resp_idx] : 8'h00;
        resp_idx++;
      end
    end else if (spi_sclk && !slave_prev_sclk) begin
      slave_shift = {slave_shift[6:0], spi_mosi};
      slave_bits++;
      if (slave_bits == 8) begin
        slave_rx_q.push_back(slave_shift);
        slave_bits = 0;
      end
    end else if (!spi_sclk && slave_prev_sclk) begin
      if (slave_bits == 0) begin
        if (!loopback) begin
          slave_tx = (resp_idx < 5) ? RESP[resp_idx] : 8'h00;
          resp_idx++;
        end
      end else begin
        slave_tx = {slave_tx[6:0], 1'b0};
      end
    end
    slave_prev_sclk = spi_sclk;
    slave_prev_cs   = spi_cs_n;
  end

  assign spi_miso   = loopback ? spi_mosi : slave_tx[7];
  assign spi_miso_2 = spi_mosi_2;

  int   cycle = 0;
  int   accept_count = 0, accept_edge = 0;
  logic accept_rx_valid = 1'b0;
  int   accept_edge_2 = 0;
  logic accept_busy_2 = 1'b0;

  always @(posedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      accept_count++;
      accept_edge = cycle;
      accept_rx_valid = rx_valid;
    end
    if (rst_n && tx_valid_2 && tx_ready_2) begin
      accept_edge_2 = cycle;
      accept_busy_2 = busy_2;
    end
    cycle++;
  end

  // Waveform monitors, sampled mid-cycle.
  logic       prev_sclk = 1'b0, prev_cs = 1'b1, prev_ready_busy = 1'b0;
  int         run_len = 0, rise_count = 0, rise_since_cs = 0;
  int         bad_high = 0, bad_low = 0, last_fall_edge = 0, cs_rise_edge = 0;
  int         cs_rise_count = 0, ready_with_sclk = 0, ready_busy_rise = 0;
  int         mosi_bits = 0;
  logic [7:0] mosi_shift = 8'h00;
  logic [7:0] mosi_q[$];
  logic [7:0] rx_q[$];
  int         rx_edge_q[$];

  always @(negedge clk) begin
    if (spi_sclk !== prev_sclk) begin
      if (spi_sclk) begin
        rise_count++;
        if ((rise_since_cs % 8) != 0 && run_len != 4) bad_low++;
        rise_since_cs++;
        mosi_shift = {mosi_shift[6:0], spi_mosi};
        mosi_bits++;
        if (mosi_bits == 8) begin
          mosi_q.push_back(mosi_shift);
          mosi_bits = 0;
        end
      end else if (!spi_cs_n) begin
        if (run_len != 4) bad_high++;
        last_fall_edge = cycle - 1;
      end
      run_len = 1;
    end else begin
      run_len++;
    end
    if (spi_cs_n) begin
      rise_since_cs = 0;
      mosi_bits = 0;
    end
    if (spi_cs_n && !prev_cs) begin
      cs_rise_edge = cycle - 1;
      cs_rise_count++;
    end
    if (spi_sclk && tx_ready) ready_with_sclk++;
    if (tx_ready && busy && !prev_ready_busy) ready_busy_rise++;
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      rx_edge_q.push_back(cycle - 1);
    end
    prev_ready_busy = tx_ready && busy;
    prev_sclk = spi_sclk;
    prev_cs = spi_cs_n;
  end

  logic       prev_sclk_2 = 1'b0, prev_cs_2 = 1'b1;
  int         rise_since_cs_2 = 0, prev_rise_2 = 0, bad_period_2 = 0;
  int         cs_high_run_2 = 0, cs_high_len_2 = 0;
  logic [7:0] rx_q_2[$];
  int         rx_edge_q_2[$];

  always @(negedge clk) begin
    if (spi_sclk_2 && !prev_sclk_2) begin
      if ((rise_since_cs_2 % 8) != 0 && (cycle - 1 - prev_rise_2) != 4) bad_period_2++;
      prev_rise_2 = cycle - 1;
      rise_since_cs_2++;
    end
    if (spi_cs_n_2) begin
      rise_since_cs_2 = 0;
      cs_high_run_2++;
    end else begin
      if (prev_cs_2) cs_high_len_2 = cs_high_run_2;
      cs_high_run_2 = 0;
    end
    if (rx_valid_2) begin
      rx_q_2.push_back(rx_data_2);
      rx_edge_q_2.push_back(cycle - 1);
    end
    prev_sclk_2 = spi_sclk_2;
    prev_cs_2 = spi_cs_n_2;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offers one byte and returns just after the accepting edge; keep_valid leaves tx_valid high.
  task automatic applyStimulus(input int which, input logic [7:0] data, input logic last,
                               input logic keep_valid);
    int n;
    n = 0;
    @(negedge clk);
    if (which == 1) begin
      tx_valid = 1'b1; tx_data = data; tx_last = last;
    end else begin
      tx_valid_2 = 1'b1; tx_data_2 = data; tx_last_2 = last;
    end
    while (!((which == 1) ? tx_ready : tx_ready_2) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) checkOutput("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    if (!keep_valid) begin
      if (which == 1) tx_valid = 1'b0;
      else            tx_valid_2 = 1'b0;
    end
  endtask

  task automatic waitRx(input int which, input int target);
    int n;
    n = 0;
    while (((which == 1) ? rx_q.size() : rx_q_2.size()) < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checkOutput("rx_wait", 32'(((which == 1) ? rx_q.size() : rx_q_2.size()) >= target), 32'd1);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  int r0, bh0, bl0, rx0, acc0, csr0, rwb0, rbr0, mq0, sq0, rx2_0, n;

  initial begin
    rst_n = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    tx_valid_2 = 1'b0; tx_data_2 = 8'h00; tx_last_2 = 1'b0;
    waitCycles(3);
    @(negedge clk);
    checkOutput("rst_cs_n", 32'(spi_cs_n), 32'd1);
    checkOutput("rst_sclk", 32'(spi_sclk), 32'd0);
    checkOutput("rst_mosi", 32'(spi_mosi), 32'd0);
    checkOutput("rst_tx_ready", 32'(tx_ready), 32'd0);
    checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    waitCycles(3);

    // Test 1: loopback 0xA5, single byte
    r0 = rise_count; bh0 = bad_high; bl0 = bad_low; rx0 = rx_q.size();
    applyStimulus(1, 8'hA5, 1'b1, 1'b0);
    waitRx(1, rx0 + 1);
    waitCycles(12);
    checkOutput("t1_pulses", 32'(rise_count - r0), 32'd8);
    checkOutput("t1_bad_high", 32'(bad_high - bh0), 32'd0);
    checkOutput("t1_bad_low", 32'(bad_low - bl0), 32'd0);
    checkOutput("t1_rx_count", 32'(rx_q.size() - rx0), 32'd1);
    checkOutput("t1_rx_data", 32'(rx_q[rx0]), 32'hA5);
    checkOutput("t1_latency", 32'(rx_edge_q[rx0] - accept_edge), 32'd67);
    checkOutput("t1_cs_hold", 32'(cs_rise_edge - last_fall_edge), 32'd2);
    checkOutput("t1_idle", 32'(busy), 32'd0);

    // Test 2: three-byte burst against the responder slave
    loopback = 1'b0;
    rx0 = rx_q.size(); csr0 = cs_rise_count; rwb0 = ready_with_sclk;
    rbr0 = ready_busy_rise; sq0 = slave_rx_q.size();
    applyStimulus(1, 8'h01, 1'b0, 1'b0);
    applyStimulus(1, 8'h80, 1'b0, 1'b0);
    applyStimulus(1, 8'hFF, 1'b1, 1'b0);
    waitRx(1, rx0 + 3);
    checkOutput("t2_cs_low_burst", 32'(cs_rise_count - csr0), 32'd0);
    waitCycles(12);
    checkOutput("t2_rx0", 32'(rx_q[rx0]), 32'h3C);
    checkOutput("t2_rx1", 32'(rx_q[rx0 + 1]), 32'hC3);
    checkOutput("t2_rx2", 32'(rx_q[rx0 + 2]), 32'h00);
    checkOutput("t2_slave_rx0", 32'(slave_rx_q[sq0]), 32'h01);
    checkOutput("t2_slave_rx1", 32'(slave_rx_q[sq0 + 1]), 32'h80);
    checkOutput("t2_slave_rx2", 32'(slave_rx_q[sq0 + 2]), 32'hFF);
    checkOutput("t2_ready_in_xfer", 32'(ready_with_sclk - rwb0), 32'd0);
    checkOutput("t2_next_gaps", 32'(ready_busy_rise - rbr0), 32'd2);
    loopback = 1'b1;

    // Test 3: 0x55 held valid during the 0xAA transfer
    rx0 = rx_q.size(); acc0 = accept_count; mq0 = mosi_q.size();
    applyStimulus(1, 8'hAA, 1'b0, 1'b1);
    tx_data = 8'h55; tx_last = 1'b1;
    applyStimulus(1, 8'h55, 1'b1, 1'b0);
    checkOutput("t3_accepts", 32'(accept_count - acc0), 32'd2);
    checkOutput("t3_accept_in_next", 32'(accept_rx_valid), 32'd1);
    waitRx(1, rx0 + 2);
    waitCycles(12);
    checkOutput("t3_accept_after_rx", 32'(accept_edge - rx_edge_q[rx0]), 32'd1);
    checkOutput("t3_mosi0", 32'(mosi_q[mq0]), 32'hAA);
    checkOutput("t3_mosi1", 32'(mosi_q[mq0 + 1]), 32'h55);
    checkOutput("t3_rx1", 32'(rx_q[rx0 + 1]), 32'h55);

    // Test 4: reset during bit 4
    rx0 = rx_q.size();
    applyStimulus(1, 8'hC3, 1'b1, 1'b0);
    n = 0;
    while (rise_since_cs < 4 && n < 500) begin
      @(posedge clk);
      n++;
    end
    checkOutput("t4_reached_bit4", 32'(rise_since_cs), 32'd4);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t4_cs_n", 32'(spi_cs_n), 32'd1);
    checkOutput("t4_sclk", 32'(spi_sclk), 32'd0);
    checkOutput("t4_busy", 32'(busy), 32'd0);
    checkOutput("t4_tx_ready", 32'(tx_ready), 32'd0);
    rst_n = 1'b1;
    waitCycles(100);
    checkOutput("t4_no_rx", 32'(rx_q.size() - rx0), 32'd0);
    applyStimulus(1, 8'h0F, 1'b1, 1'b0);
    waitRx(1, rx0 + 1);
    checkOutput("t4_rx_after", 32'(rx_q[rx0]), 32'h0F);
    waitCycles(12);

    // Test 5: fastest timing, back-to-back single-byte bursts
    rx2_0 = rx_q_2.size();
    applyStimulus(2, 8'h96, 1'b1, 1'b0);
    n = accept_edge_2;
    applyStimulus(2, 8'h69, 1'b1, 1'b0);
    checkOutput("t5_second_from_idle", 32'(accept_busy_2), 32'd0);
    waitRx(2, rx2_0 + 2);
    checkOutput("t5_rx0", 32'(rx_q_2[rx2_0]), 32'h96);
    checkOutput("t5_rx1", 32'(rx_q_2[rx2_0 + 1]), 32'h69);
    checkOutput("t5_latency", 32'(rx_edge_q_2[rx2_0] - n), 32'd34);
    checkOutput("t5_sclk_period", 32'(bad_period_2), 32'd0);
    checkOutput("t5_cs_gap", 32'(cs_high_len_2 >= 1), 32'd1);
    waitCycles(8);

    // Test 6: slave link exchange, 0x5A out and preloaded 0xA7 back
    loopback = 1'b0;
    rx0 = rx_q.size(); sq0 = slave_rx_q.size();
    applyStimulus(1, 8'h5A, 1'b1, 1'b0);
    waitRx(1, rx0 + 1);
    waitCycles(12);
    checkOutput("t6_slave_rx", 32'(slave_rx_q[sq0]), 32'h5A);
    checkOutput("t6_master_rx", 32'(rx_q[rx0]), 32'hA7);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
